// File: rtl/us_trig_gen.sv
// Ultrasonic ranger sequencer: fires a trig pulse, times the echo window and
// paces trigger-to-trigger spacing at PERIOD_US cycles of clk_1m.
module us_trig_gen #(
    parameter int unsigned TRIG_US     = 10,
    parameter int unsigned PERIOD_US   = 60000,
    parameter int unsigned WAIT_US     = 1000,
    parameter int unsigned ECHO_MAX_US = 38000
) (
    input  logic clk_1m,
    input  logic rst,
    input  logic en,
    input  logic start,
    input  logic echo,
    output logic trig,
    output logic busy,
    output logic cycle_done,
    output logic timeout
);

    localparam int unsigned PW    = $clog2(PERIOD_US) + 1;
    localparam int unsigned SMAX0 = (TRIG_US > WAIT_US) ? TRIG_US : WAIT_US;
    localparam int unsigned SMAX  = (SMAX0 > ECHO_MAX_US) ? SMAX0 : ECHO_MAX_US;
    localparam int unsigned SW    = $clog2(SMAX) + 1;

    localparam logic [PW-1:0] PCNT_LAST = PW'(PERIOD_US - 1);
    localparam logic [SW-1:0] TRIG_LAST = SW'(TRIG_US - 1);
    localparam logic [SW-1:0] WAIT_LAST = SW'(WAIT_US - 1);
    localparam logic [SW-1:0] ECHO_LAST = SW'(ECHO_MAX_US - 1);

    typedef enum logic [2:0] {
        StIdle,
        StTrig,
        StWaitEcho,
        StEchoHigh,
        StHoldoff
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic          fail_q, fail_d;
    logic          done_d;
    logic          trig_q, cycle_done_q, timeout_q;

    logic echo_m, echo_s, echo_d;
    logic rise, fall;

    // Two-flop synchroniser plus one delay stage for edge detection.
    always_ff @(posedge clk_1m or negedge rst) begin
        if (!rst) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
            echo_d <= 1'b0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
            echo_d <= echo_s;
        end
    end

    assign rise = echo_s & ~echo_d;
    assign fall = ~echo_s & echo_d;

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q + SW'(1);
        pcnt_d  = (pcnt_q == PCNT_LAST) ? pcnt_q : pcnt_q + PW'(1);
        fail_d  = fail_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                scnt_d = '0;
                pcnt_d = '0;
                if (en || start) begin
                    state_d = StTrig;
                end
            end

            StTrig: begin
                if (scnt_q == TRIG_LAST) begin
                    state_d = StWaitEcho;
                    scnt_d  = '0;
                end
            end

            // A rise seen on the last allowed cycle still wins over the timeout.
            StWaitEcho: begin
                if (rise) begin
                    state_d = StEchoHigh;
                    scnt_d  = '0;
                end else if (scnt_q == WAIT_LAST) begin
                    state_d = StHoldoff;
                    fail_d  = 1'b1;
                    done_d  = 1'b1;
                end
            end

            StEchoHigh: begin
                if (fall) begin
                    state_d = StHoldoff;
                    fail_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (scnt_q == ECHO_LAST) begin
                    state_d = StHoldoff;
                    fail_d  = 1'b1;
                    done_d  = 1'b1;
                end
            end

            // cycle_done_q marks the entry cycle, which must not exit even if saturated.
            StHoldoff: begin
                scnt_d = '0;
                if (!cycle_done_q && (pcnt_q == PCNT_LAST)) begin
                    if (en) begin
                        state_d = StTrig;
                        pcnt_d  = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end

            default: begin
                state_d = StIdle;
                scnt_d  = '0;
                pcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_1m or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            pcnt_q       <= '0;
            scnt_q       <= '0;
            fail_q       <= 1'b0;
            trig_q       <= 1'b0;
            cycle_done_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            scnt_q       <= scnt_d;
            fail_q       <= fail_d;
            trig_q       <= (state_d == StTrig);
            cycle_done_q <= done_d;
            timeout_q    <= done_d & fail_d;
        end
    end

    assign trig       = trig_q;
    assign cycle_done = cycle_done_q;
    assign timeout    = timeout_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_us_trig_gen.sv
// Bench for us_trig_gen: timestamp-based window model checked every cycle,
// directed windows pinned to hand-computed offsets, then randomized traffic.
module tb_us_trig_gen;

    localparam int unsigned T = 4;
    localparam int unsigned P = 24;
    localparam int unsigned W = 8;
    localparam int unsigned E = 12;

    logic clk_1m, rst, en, start, echo;
    logic trig, busy, cycle_done, timeout;

    int unsigned checks;
    int unsigned errors;

    int n_trig, n_rise, rise1, rise2, n_done, d1_k, d1_to, done_k, done_to, n_busy;
    logic prev_trig;

    us_trig_gen #(
        .TRIG_US    (T),
        .PERIOD_US  (P),
        .WAIT_US    (W),
        .ECHO_MAX_US(E)
    ) dut (
        .clk_1m    (clk_1m),
        .rst       (rst),
        .en        (en),
        .start     (start),
        .echo      (echo),
        .trig      (trig),
        .busy      (busy),
        .cycle_done(cycle_done),
        .timeout   (timeout)
    );

    initial begin
        clk_1m = 1'b0;
        forever #5 clk_1m = ~clk_1m;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Window model in absolute cycle numbers: t0 first trig cycle, es first
    // echo-high cycle, dn cycle of the cycle_done strobe (-1 while unknown).
    initial begin : model
        int c, t0, es, dn;
        bit act, to, h1, h2, h3, rs, fl;
        c = 0; t0 = 0; es = -1; dn = -1;
        act = 0; to = 0; h1 = 0; h2 = 0; h3 = 0;
        forever begin
            @(negedge clk_1m);
            c++;
            if (!rst) begin
                act = 0; es = -1; dn = -1;
                h1 = 0; h2 = 0; h3 = 0;
                chk("rst_trig", trig, 0);
                chk("rst_busy", busy, 0);
                chk("rst_cycle_done", cycle_done, 0);
                chk("rst_timeout", timeout, 0);
            end else begin
                rs = h2 & ~h3;
                fl = ~h2 & h3;
                chk("trig", trig, int'(act && (c < t0 + int'(T))));
                chk("busy", busy, int'(act));
                chk("cycle_done", cycle_done, int'(act && dn == c));
                chk("timeout", timeout, int'(act && dn == c && to));
                if (!act) begin
                    if (en || start) begin
                        act = 1; t0 = c + 1; es = -1; dn = -1;
                    end
                end else if (dn < 0) begin
                    if (es < 0) begin
                        if (c >= t0 + int'(T)) begin
                            if (rs) es = c + 1;
                            else if (c == t0 + int'(T) + int'(W) - 1) begin
                                dn = c + 1; to = 1;
                            end
                        end
                    end else if (c >= es) begin
                        if (fl) begin
                            dn = c + 1; to = 0;
                        end else if (c == es + int'(E) - 1) begin
                            dn = c + 1; to = 1;
                        end
                    end
                end else if (c > dn && c >= t0 + int'(P) - 1) begin
                    if (en) begin
                        t0 = c + 1; es = -1; dn = -1;
                    end else begin
                        act = 0;
                    end
                end
                h3 = h2; h2 = h1; h1 = echo;
            end
        end
    end

    task automatic tick(input logic e, input logic s, input logic ec);
        @(posedge clk_1m);
        #1;
        en = e; start = s; echo = ec;
        @(negedge clk_1m);
    endtask

    task automatic clr_obs();
        n_trig = 0; n_rise = 0; rise1 = -1; rise2 = -1; n_done = 0;
        d1_k = -1; d1_to = -1; done_k = -1; done_to = -1; n_busy = 0;
        prev_trig = trig;
    endtask

    task automatic obs(input int k);
        if (trig) n_trig++;
        if (trig && !prev_trig) begin
            n_rise++;
            if (n_rise == 1) rise1 = k;
            else if (n_rise == 2) rise2 = k;
        end
        prev_trig = trig;
        if (cycle_done) begin
            n_done++;
            if (n_done == 1) begin
                d1_k = k; d1_to = int'(timeout);
            end
            done_k = k; done_to = int'(timeout);
        end
        if (busy) n_busy++;
    endtask

    task automatic do_reset();
        @(posedge clk_1m);
        #2 rst = 1'b0;
        @(posedge clk_1m);
        @(posedge clk_1m);
        #3 rst = 1'b1;
    endtask

    initial begin : stim
        int run;
        logic enr, ev;
        checks = 0; errors = 0;
        rst = 1'b0; en = 1'b0; start = 1'b0; echo = 1'b0;
        repeat (3) @(posedge clk_1m);
        #3 rst = 1'b1;

        // Single shot, no echo: wait timeout 12 cycles after first trig.
        clr_obs();
        tick(0, 1, 0);
        for (int k = 1; k <= 30; k++) begin
            tick(0, 0, 0);
            obs(k);
        end
        chk("a_first_trig", rise1, 1);
        chk("a_trig_len", n_trig, 4);
        chk("a_done_at", done_k, 13);
        chk("a_timeout", done_to, 1);
        chk("a_done_count", n_done, 1);
        chk("a_busy_len", n_busy, 24);

        // Continuous mode with a 5-cycle echo, then en dropped mid second window.
        clr_obs();
        tick(1, 0, 0);
        for (int k = 1; k <= 60; k++) begin
            tick(k <= 26, 0, (k - 1 >= 6) && (k - 1 <= 10));
            obs(k);
        end
        chk("b_first_trig", rise1, 1);
        chk("b_second_trig", rise2, 25);
        chk("b_rises", n_rise, 2);
        chk("b_done1_at", d1_k, 15);
        chk("b_done1_timeout", d1_to, 0);
        chk("b_done_count", n_done, 2);
        chk("b_last_timeout", done_to, 1);
        chk("b_busy_len", n_busy, 48);

        // start held while busy: one window only.
        clr_obs();
        tick(0, 1, 0);
        for (int k = 1; k <= 30; k++) begin
            tick(0, k <= 22, 0);
            obs(k);
        end
        chk("c_rises", n_rise, 1);
        chk("c_done_count", n_done, 1);
        chk("c_busy_len", n_busy, 24);

        // Echo already high at trig, then a glitch inside holdoff.
        repeat (3) tick(0, 0, 1);
        clr_obs();
        tick(0, 1, 1);
        for (int k = 1; k <= 30; k++) begin
            tick(0, 0, (k - 1 <= 13) || (k - 1 == 17));
            obs(k);
        end
        chk("e_done_at", d1_k, 13);
        chk("e_timeout", d1_to, 1);
        chk("e_done_count", n_done, 1);
        chk("e_busy_len", n_busy, 24);

        // Reset asserted while echo is high.
        clr_obs();
        tick(0, 1, 0);
        for (int k = 1; k <= 13; k++) begin
            tick(0, 0, k - 1 >= 5);
            obs(k);
        end
        chk("d_busy_before", int'(busy), 1);
        @(posedge clk_1m);
        #1 en = 1'b0; start = 1'b0; echo = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("d_trig_now", int'(trig), 0);
        chk("d_busy_now", int'(busy), 0);
        chk("d_done_now", int'(cycle_done), 0);
        chk("d_timeout_now", int'(timeout), 0);
        @(posedge clk_1m);
        @(posedge clk_1m);
        #3 rst = 1'b1;
        clr_obs();
        for (int k = 1; k <= 30; k++) begin
            tick(0, 0, (k % 3) == 0);
            obs(k);
        end
        chk("d_busy_after", n_busy, 0);
        chk("d_done_after", n_done, 0);
        chk("d_rises_after", n_rise, 0);

        // Randomized traffic with occasional resets.
        enr = 1'b0; ev = 1'b0; run = 0;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 39) == 0) enr = ~enr;
            if (run == 0) begin
                ev = ~ev;
                run = int'($urandom_range(1, 20));
            end
            run--;
            if ($urandom_range(0, 999) == 0) do_reset();
            tick(enr, $urandom_range(0, 24) == 0, ev);
        end
        repeat (40) tick(0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
